comparator_seq: RTL and testbench
=================================

Name: comparator_seq

Overview:
Parametrised, multi-cycle magnitude comparator for the execute/branch path. It compares operands of configurable width, CHUNK bits per cycle, starting at the MSB, and stops early at the first differing chunk. Signed or unsigned mode is chosen per operation. A valid/ready handshake is used on both input and output, and exactly one of lt/eq/gt is reported. It is intended for wide-operand or area-constrained variants where a single-cycle 32-bit compare is too costly.

Parameters:
WIDTH, 32, operand width in bits; must be at least 2.
CHUNK, 4, bits examined per cycle; WIDTH % CHUNK must be 0, otherwise elaboration fails.
NUM_STEPS, WIDTH/CHUNK, derived local parameter; not overridable.

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  reset, asynchronous, active-low.
i_valid  in  1  request valid.
o_ready  out  1  block can accept a request.
i_a  in  WIDTH  operand a.
i_b  in  WIDTH  operand b.
i_unsigned_op  in  1  1 = unsigned compare, 0 = two's-complement signed.
i_abort  in  1  synchronous cancel of the in-flight operation.
o_valid  out  1  result valid.
i_ready  in  1  consumer accepts the result.
o_a_lt_b  out  1  a < b.
o_a_eq_b  out  1  a == b.
o_a_gt_b  out  1  a > b.

Behaviour:
- Reset: asynchronous on i_rst_n low.
  - State goes to IDLE.
  - o_valid = 0; o_a_lt_b / o_a_eq_b / o_a_gt_b = 0.
  - Captured operands and step counter = 0.
  - o_ready = 1 while in IDLE, including during reset.
- States: IDLE, RUN, DONE.
  - o_ready = (state == IDLE), decoded from registered state.
  - o_valid = (state == DONE), registered.
- IDLE to RUN when i_valid && o_ready at an edge:
  - Capture a and b; step counter = NUM_STEPS-1 (MSB chunk first).
  - Signed mode: invert bit WIDTH-1 of both captured operands. An unsigned compare then gives the signed result. Equality is unaffected.
- RUN, each cycle: compare chunk [step*CHUNK +: CHUNK] of both captured operands as unsigned values.
  - Chunks differ: at the next edge, register lt = (a_chunk < b_chunk), gt = !lt, eq = 0; go to DONE.
  - Chunks equal and step == 0: register eq = 1, lt = gt = 0; go to DONE.
  - Chunks equal and step > 0: decrement step; stay in RUN.
- Latency from the accepting edge to o_valid high is j cycles.
  - j = 1-based index, counted from the MSB, of the first differing chunk.
  - Equal operands give j = NUM_STEPS.
- DONE:
  - Results are held stable while o_valid && !i_ready; no output may change under backpressure.
  - On i_ready the state returns to IDLE at the edge and o_valid drops.
  - Result flags keep their last value after the handshake and are meaningful only while o_valid = 1.
- One operation in flight at a time. i_valid in RUN/DONE is ignored and is not queued.
- Best-case throughput: one operation per j+2 cycles.
- i_abort:
  - In RUN or DONE: return to IDLE at the next edge; o_valid = 0 and no result handshake occurs.
  - Has priority over the completion decision and over i_ready.
  - In IDLE it is ignored, so an acceptance in the same cycle proceeds.
- Invariant: when o_valid = 1, exactly one of lt/eq/gt is 1.
- Reset asserted mid-operation: immediate IDLE; the operation is lost.

Decomposition:
- Shared package comparator_pkg:
  - State enum (IDLE, RUN, DONE).
  - Result-flag bit positions (LT, EQ, GT) as constants.
- One combinational sub-module, comparator_chunk:
  - Parametrised width, unsigned inputs a and b.
  - Outputs lt and eq.
  - Instantiated once, fed by the step-indexed slice mux.

Test Plan:
All scenarios use WIDTH=32, CHUNK=4.
1. Unsigned, a=0x00000005, b=0x00000005 -> o_valid 8 cycles after accept; eq=1, lt=0, gt=0.
2. Unsigned, a=0x80000000, b=0x7FFFFFFF -> o_valid 1 cycle after accept; gt=1.
3. Signed, a=0x80000000, b=0x7FFFFFFF -> o_valid after 1 cycle; lt=1.
4. Signed, a=0xFFFFFFFE (-2), b=0xFFFFFFFF (-1) -> latency 8; lt=1. Then swap operands -> gt=1.
5. Backpressure: hold i_ready=0 for 5 cycles after o_valid, and pulse i_valid with new operands -> flags stable, o_ready=0, new request not taken. On i_ready=1, IDLE next cycle and o_ready=1.
6. Equal operands with i_abort at the 3rd RUN cycle -> o_valid never asserts, o_ready=1 next cycle. Repeat with i_rst_n pulsed low mid-RUN -> all outputs 0 immediately, o_ready=1.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
package comparator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned FLAG_LT   = 0;
    localparam int unsigned FLAG_EQ   = 1;
    localparam int unsigned FLAG_GT   = 2;
    localparam int unsigned NUM_FLAGS = 3;

endpackage

// File: rtl/comparator_chunk.sv
// Unsigned compare of one operand chunk.
module comparator_chunk #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt,
    output logic         eq
);

    // Pure combinational magnitude/equality decode
    always_comb begin
        lt = (a < b);
        eq = (a == b);
    end

endmodule

// File: rtl/comparator_seq.sv
// Multi-cycle MSB-first magnitude comparator with early exit and valid/ready handshakes.
module comparator_seq
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_unsigned_op,
    input  logic             i_abort,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_a_lt_b,
    output logic             o_a_eq_b,
    output logic             o_a_gt_b
);

    localparam int unsigned NUM_STEPS = WIDTH / CHUNK;
    localparam int unsigned STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    // Reject parameter sets that cannot be split into whole chunks
    if ((WIDTH < 2) || (CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("comparator_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic [STEP_W-1:0]      step_q, step_d;
    logic [NUM_FLAGS-1:0]   flags_q, flags_d;
    logic                   valid_q;

    logic [WIDTH-1:0]       a_sh, b_sh;
    logic [CHUNK-1:0]       a_chunk, b_chunk;
    logic                   chunk_lt, chunk_eq;

    // Step-indexed slice mux feeding the single chunk comparator
    always_comb begin
        a_sh    = a_q >> (32'(step_q) * CHUNK);
        b_sh    = b_q >> (32'(step_q) * CHUNK);
        a_chunk = a_sh[CHUNK-1:0];
        b_chunk = b_sh[CHUNK-1:0];
    end

    comparator_chunk #(
        .W (CHUNK)
    ) u_chunk (
        .a  (a_chunk),
        .b  (b_chunk),
        .lt (chunk_lt),
        .eq (chunk_eq)
    );

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            step_q  <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            step_q  <= step_d;
            flags_q <= flags_d;
            valid_q <= (state_d == ST_DONE);
        end
    end

    // Next-state and datapath update; abort outranks completion and i_ready
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        step_d  = step_q;
        flags_d = flags_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    state_d = ST_RUN;
                    a_d     = i_a;
                    b_d     = i_b;
                    step_d  = STEP_W'(NUM_STEPS - 1);
                    // Flipping the sign bits maps two's-complement order onto unsigned order
                    if (!i_unsigned_op) begin
                        a_d[WIDTH-1] = ~i_a[WIDTH-1];
                        b_d[WIDTH-1] = ~i_b[WIDTH-1];
                    end
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (!chunk_eq) begin
                    flags_d          = '0;
                    flags_d[FLAG_LT] = chunk_lt;
                    flags_d[FLAG_GT] = ~chunk_lt;
                    state_d          = ST_DONE;
                end else if (step_q == '0) begin
                    flags_d          = '0;
                    flags_d[FLAG_EQ] = 1'b1;
                    state_d          = ST_DONE;
                end else begin
                    step_d = step_q - STEP_W'(1);
                end
            end
            ST_DONE: begin
                if (i_abort || i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_ready  = (state_q == ST_IDLE);
    assign o_valid  = valid_q;
    assign o_a_lt_b = flags_q[FLAG_LT];
    assign o_a_eq_b = flags_q[FLAG_EQ];
    assign o_a_gt_b = flags_q[FLAG_GT];

endmodule

// File: tb/tb_comparator_seq.sv
// Directed self-checking bench for comparator_seq (WIDTH=32, CHUNK=4).
module tb_comparator_seq;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CHUNK = 4;
    localparam int          TMO   = 40;

    logic             clk;
    logic             rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_unsigned_op;
    logic             i_abort;
    logic             o_valid;
    logic             i_ready;
    logic             o_a_lt_b;
    logic             o_a_eq_b;
    logic             o_a_gt_b;

    int errors = 0;
    int checks = 0;

    comparator_seq #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_a           (i_a),
        .i_b           (i_b),
        .i_unsigned_op (i_unsigned_op),
        .i_abort       (i_abort),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_a_lt_b      (o_a_lt_b),
        .o_a_eq_b      (o_a_eq_b),
        .o_a_gt_b      (o_a_gt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait (bounded) for o_valid; returns latency and flags
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic uns, output int lat, output logic [2:0] f);
        i_a           = a;
        i_b           = b;
        i_unsigned_op = uns;
        i_valid       = 1'b1;
        step();
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < TMO) begin
            step();
            lat++;
        end
        f = {o_a_gt_b, o_a_eq_b, o_a_lt_b};
    endtask

    // Complete the result handshake
    task automatic consume();
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
    endtask

    // Compare one operation against hand-computed latency and {gt,eq,lt}
    task automatic test_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic uns, input int exp_lat, input logic [2:0] exp_f);
        int         lat;
        logic [2:0] f;
        run_op(a, b, uns, lat, f);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (f !== exp_f) begin
            errors++;
            $display("FAIL %s flags{gt,eq,lt}: got %b expected %b", name, f, exp_f);
        end
        consume();
        checks++;
        if ({o_valid, o_ready} !== 2'b01) begin
            errors++;
            $display("FAIL %s after handshake {valid,ready}: got %b expected 01", name, {o_valid, o_ready});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({o_ready, o_valid, o_a_lt_b, o_a_eq_b, o_a_gt_b} !== 5'b10000) begin
            errors++;
            $display("FAIL reset outputs {ready,valid,lt,eq,gt}: got %b expected 10000",
                     {o_ready, o_valid, o_a_lt_b, o_a_eq_b, o_a_gt_b});
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({o_ready, o_valid} !== 2'b10) begin
            errors++;
            $display("FAIL post-reset idle {ready,valid}: got %b expected 10", {o_ready, o_valid});
        end
    endtask

    task automatic test_unsigned();
        test_op("uns_eq_5",    32'h0000_0005, 32'h0000_0005, 1'b1, 8, 3'b010);
        test_op("uns_msb_gt",  32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1, 3'b100);
        test_op("uns_mid_gt",  32'h1234_5678, 32'h1230_5678, 1'b1, 4, 3'b100);
        test_op("uns_lsb_lt",  32'hFFFF_FFF0, 32'hFFFF_FFF1, 1'b1, 8, 3'b001);
    endtask

    task automatic test_signed();
        test_op("sgn_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1, 3'b001);
        test_op("sgn_m2_m1",   32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 8, 3'b001);
        test_op("sgn_m1_m2",   32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 8, 3'b100);
        test_op("sgn_eq_neg",  32'h8000_0001, 32'h8000_0001, 1'b0, 8, 3'b010);
    endtask

    task automatic test_backpressure();
        int         lat;
        logic [2:0] f;
        run_op(32'h0000_0100, 32'h0000_0200, 1'b1, lat, f);
        checks++;
        if (f !== 3'b001 || lat !== 6) begin
            errors++;
            $display("FAIL bp first result: got lat=%0d f=%b expected lat=6 f=001", lat, f);
        end
        for (int i = 0; i < 5; i++) begin
            i_a           = 32'hFFFF_FFFF;
            i_b           = 32'h0000_0000;
            i_unsigned_op = 1'b1;
            i_valid       = (i % 2) == 0;
            step();
            checks++;
            if ({o_valid, o_ready, o_a_gt_b, o_a_eq_b, o_a_lt_b} !== 5'b10001) begin
                errors++;
                $display("FAIL bp hold cycle %0d {valid,ready,gt,eq,lt}: got %b expected 10001",
                         i, {o_valid, o_ready, o_a_gt_b, o_a_eq_b, o_a_lt_b});
            end
        end
        i_valid = 1'b0;
        consume();
        checks++;
        if ({o_valid, o_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp release {valid,ready}: got %b expected 01", {o_valid, o_ready});
        end
        step();
        checks++;
        if ({o_valid, o_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp no queued request {valid,ready}: got %b expected 01", {o_valid, o_ready});
        end
    endtask

    task automatic test_abort();
        int seen = 0;
        i_a           = 32'hA5A5_A5A5;
        i_b           = 32'hA5A5_A5A5;
        i_unsigned_op = 1'b1;
        i_valid       = 1'b1;
        step();
        i_valid = 1'b0;
        step();
        step();
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        checks++;
        if ({o_valid, o_ready} !== 2'b01) begin
            errors++;
            $display("FAIL abort run {valid,ready}: got %b expected 01", {o_valid, o_ready});
        end
        for (int i = 0; i < 12; i++) begin
            if (o_valid) seen++;
            step();
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort no result: got %0d valid cycles expected 0", seen);
        end
        // Abort during DONE beats i_ready and suppresses the handshake
        i_a     = 32'h1000_0000;
        i_b     = 32'h0000_0000;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        step();
        i_abort = 1'b1;
        i_ready = 1'b1;
        checks++;
        if (o_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort done precondition valid: got %b expected 1", o_valid);
        end
        step();
        i_abort = 1'b0;
        i_ready = 1'b0;
        checks++;
        if ({o_valid, o_ready} !== 2'b01) begin
            errors++;
            $display("FAIL abort done {valid,ready}: got %b expected 01", {o_valid, o_ready});
        end
    endtask

    task automatic test_abort_idle();
        int         lat;
        logic [2:0] f;
        i_abort = 1'b1;
        i_a     = 32'h0000_0003;
        i_b     = 32'h0000_0030;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        i_abort = 1'b0;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort idle accept ready: got %b expected 0", o_ready);
        end
        lat = 0;
        while (!o_valid && lat < TMO) begin
            step();
            lat++;
        end
        f = {o_a_gt_b, o_a_eq_b, o_a_lt_b};
        checks++;
        if (lat !== 7 || f !== 3'b001) begin
            errors++;
            $display("FAIL abort idle result: got lat=%0d f=%b expected lat=7 f=001", lat, f);
        end
        consume();
    endtask

    task automatic test_reset_mid_run();
        i_a           = 32'h0F0F_0F0F;
        i_b           = 32'h0F0F_0F0F;
        i_unsigned_op = 1'b1;
        i_valid       = 1'b1;
        step();
        i_valid = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_ready, o_valid, o_a_lt_b, o_a_eq_b, o_a_gt_b} !== 5'b10000) begin
            errors++;
            $display("FAIL reset mid-run {ready,valid,lt,eq,gt}: got %b expected 10000",
                     {o_ready, o_valid, o_a_lt_b, o_a_eq_b, o_a_gt_b});
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if ({o_ready, o_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset mid-run lost op {ready,valid}: got %b expected 10", {o_ready, o_valid});
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        i_valid       = 1'b0;
        i_a           = '0;
        i_b           = '0;
        i_unsigned_op = 1'b1;
        i_abort       = 1'b0;
        i_ready       = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_abort();
        test_abort_idle();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
